// File: rtl/ste_led_pkg.sv
// ste_led_pkg: shared sizing, display mode encoding and LED rendering helpers for the LED meter.
// The rendering helpers are sized by LED_N; the meter's LED_NR/HOLD_TICKS defaults come from here.
package ste_led_pkg;

    localparam int LED_N  = 8;
    localparam int HOLD_N = 3;
    localparam int LVL_W  = $clog2(LED_N + 1);
    localparam int HOLD_W = $clog2(HOLD_N + 1);

    typedef enum logic {
        MODE_BAR = 1'b0,
        MODE_DOT = 1'b1
    } mode_e;

    function automatic logic [LED_N-1:0] thermo(input logic [LVL_W-1:0] n);
        logic [LED_N-1:0] t;
        for (int i = 0; i < LED_N; i++) t[i] = 32'(n) > i;
        return t;
    endfunction

    function automatic logic [LED_N-1:0] onehot_at(input logic [LVL_W-1:0] n);
        logic [LED_N-1:0] o;
        for (int i = 0; i < LED_N; i++) o[i] = 32'(n) == i + 1;
        return o;
    endfunction

endpackage

// File: rtl/ste_led_peak_ch.sv
// ste_led_peak_ch: one meter channel -- sample scaling, level/peak/hold registers and LED rendering.
module ste_led_peak_ch
    import ste_led_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LED_NR     = LED_N,
    parameter int HOLD_TICKS = HOLD_N
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              upd,
    input  logic              tick,
    input  logic              mode,
    input  logic              clr,
    output logic [LED_NR-1:0] led
);

    localparam int SW = DATA_W + $clog2(LED_NR) + 1;

    logic [SW-1:0]     sum;
    logic [LVL_W-1:0]  n;
    logic [LVL_W-1:0]  lvl;
    logic [LVL_W-1:0]  lvl_nx;
    logic [LVL_W-1:0]  pk;
    logic [LVL_W-1:0]  pk_nx;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_nx;
    logic              load;

    // ceil(din * LED_NR / 2^DATA_W): bias by 2^DATA_W-1 before dropping the fraction
    assign sum = SW'(din) * SW'(LED_NR) + SW'((2 ** DATA_W) - 1);
    assign n   = LVL_W'(sum >> DATA_W);

    // a peak load this cycle suppresses the tick; decay compares against the new level
    always_comb begin
        load    = upd && n >= pk;
        lvl_nx  = upd ? n : lvl;
        pk_nx   = load ? n : (tick && hold == '0 && pk > lvl_nx) ? pk - LVL_W'(1) : pk;
        hold_nx = load ? HOLD_W'(HOLD_TICKS) : (tick && hold != '0) ? hold - HOLD_W'(1) : hold;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl  <= '0;
            pk   <= '0;
            hold <= '0;
            led  <= '0;
        end else if (clr) begin
            lvl  <= '0;
            pk   <= '0;
            hold <= '0;
            led  <= '0;
        end else begin
            lvl  <= lvl_nx;
            pk   <= pk_nx;
            hold <= hold_nx;
            led  <= (mode_e'(mode) == MODE_DOT ? onehot_at(lvl) : thermo(lvl)) | onehot_at(pk);
        end
    end

endmodule

// File: rtl/ste_led_meter.sv
// ste_led_meter: multi-channel LED level meter with per-channel peak hold and decay.
module ste_led_meter
    import ste_led_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LED_NR     = LED_N,
    parameter int CH_NR      = 3,
    parameter int HOLD_TICKS = HOLD_N
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          din_i,
    input  logic [$clog2(CH_NR)-1:0]   din_ch_i,
    input  logic                       din_update_i,
    input  logic                       tick_i,
    input  logic                       mode_i,
    input  logic                       clr_i,
    output logic [CH_NR*LED_NR-1:0]    led_o
);

    // out-of-range channel indices match no instance, so they are dropped here
    for (genvar c = 0; c < CH_NR; c++) begin : g_ch
        ste_led_peak_ch #(
            .DATA_W    (DATA_W),
            .LED_NR    (LED_NR),
            .HOLD_TICKS(HOLD_TICKS)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (din_i),
            .upd  (din_update_i && 32'(din_ch_i) == c),
            .tick (tick_i),
            .mode (mode_i),
            .clr  (clr_i),
            .led  (led_o[c*LED_NR +: LED_NR])
        );
    end

endmodule

// File: tb/tb_ste_led_meter.sv
// tb_ste_led_meter: directed and randomized stimulus, scoreboard-checked against a behavioural meter model.
module tb_ste_led_meter;

    localparam int DW   = 8;
    localparam int LED  = 8;
    localparam int CH   = 3;
    localparam int HOLD = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DW-1:0]     din = '0;
    logic [1:0]        din_ch = '0;
    logic              din_update = 1'b0;
    logic              tick = 1'b0;
    logic              mode = 1'b0;
    logic              clr = 1'b0;
    logic [CH*LED-1:0] led;

    ste_led_meter #(
        .DATA_W    (DW),
        .LED_NR    (LED),
        .CH_NR     (CH),
        .HOLD_TICKS(HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din_i       (din),
        .din_ch_i    (din_ch),
        .din_update_i(din_update),
        .tick_i      (tick),
        .mode_i      (mode),
        .clr_i       (clr),
        .led_o       (led)
    );

    always #5 clk = ~clk;

    int m_lvl[CH];
    int m_pk[CH];
    int m_hold[CH];
    logic [CH*LED-1:0] exp_q[$];
    int n_chk = 0;
    int n_pass = 0;

    function automatic int scale(input int d);
        return (d * LED + (1 << DW) - 1) / (1 << DW);
    endfunction

    function automatic logic [CH*LED-1:0] render(input logic dot);
        logic [CH*LED-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < LED; i++)
                r[c*LED+i] = (dot ? i == m_lvl[c] - 1 : i < m_lvl[c]) || i == m_pk[c] - 1;
        return r;
    endfunction

    task automatic cmp(input string name, input logic [CH*LED-1:0] got, input logic [CH*LED-1:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    task automatic chk_ch(input int c, input logic [LED-1:0] want, input string name);
        logic [CH*LED-1:0] got;
        logic [LED-1:0] g;
        got = led;
        g = got[c*LED +: LED];
        n_chk++;
        if (g === want) n_pass++;
        else $display("FAIL %s: ch%0d got %h expected %h", name, c, g, want);
    endtask

    // drive one cycle; the led value expected after this edge is the old state rendered
    task automatic step(input logic u, input int ch, input int d, input logic t, input logic c);
        logic [CH*LED-1:0] e;
        bit loaded;
        int n;
        @(negedge clk);
        din_update = u;
        din_ch = 2'(ch);
        din = DW'(d);
        tick = t;
        clr = c;
        e = c ? '0 : render(mode);
        for (int k = 0; k < CH; k++) begin
            if (c) begin
                m_lvl[k] = 0;
                m_pk[k] = 0;
                m_hold[k] = 0;
            end else begin
                loaded = 0;
                if (u && ch == k) begin
                    n = scale(d);
                    m_lvl[k] = n;
                    if (n >= m_pk[k]) begin
                        m_pk[k] = n;
                        m_hold[k] = HOLD;
                        loaded = 1;
                    end
                end
                if (t && !loaded) begin
                    if (m_hold[k] > 0) m_hold[k]--;
                    else if (m_pk[k] > m_lvl[k]) m_pk[k]--;
                end
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #2;
        din_update = 1'b0;
        tick = 1'b0;
        clr = 1'b0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int k);
        repeat (k) step(0, 0, 0, 1, 0);
    endtask

    initial begin : monitor
        logic [CH*LED-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("scoreboard", led, e);
            end
        end
    end

    initial begin
        for (int k = 0; k < CH; k++) begin
            m_lvl[k] = 0;
            m_pk[k] = 0;
            m_hold[k] = 0;
        end
        repeat (2) @(posedge clk);
        #2;
        cmp("reset", led, '0);
        @(negedge clk);
        rst_n = 1'b1;

        step(1, 0, 8'h80, 0, 0); idle();
        chk_ch(0, 8'h0F, "t1_ch0");
        chk_ch(1, 8'h00, "t1_ch1");
        chk_ch(2, 8'h00, "t1_ch2");

        step(1, 1, 8'hFF, 0, 0); idle();
        chk_ch(1, 8'hFF, "t2_full");
        step(1, 1, 8'h20, 0, 0); idle();
        chk_ch(1, 8'h81, "t2_peak");
        ticks(3); idle();
        chk_ch(1, 8'h81, "t2_hold");
        ticks(1); idle();
        chk_ch(1, 8'h41, "t2_decay1");
        ticks(1); idle();
        chk_ch(1, 8'h21, "t2_decay2");
        ticks(7); idle();
        chk_ch(1, 8'h01, "t2_floor");

        step(1, 2, 8'h01, 0, 0); idle();
        chk_ch(2, 8'h01, "t3_min");
        step(1, 2, 8'h00, 0, 0); idle();
        chk_ch(2, 8'h01, "t3_peak_only");
        ticks(4); idle();
        chk_ch(2, 8'h00, "t3_gone");

        step(1, 0, 8'hC0, 0, 0);
        step(1, 0, 8'h80, 0, 0);
        mode = 1'b1;
        idle();
        chk_ch(0, 8'h28, "t4_dot");
        mode = 1'b0;
        idle();
        chk_ch(0, 8'h2F, "t4_bar");

        step(1, 1, 8'hFF, 1, 1);
        cmp("t5_clr", led, '0);
        ticks(1);
        cmp("t5_tick_after_clr", led, '0);
        idle();
        cmp("t5_state_zero", led, '0);

        step(1, 0, 8'h80, 0, 0); idle();
        chk_ch(0, 8'h0F, "t6_setup");
        step(1, 3, 8'hFF, 0, 0); idle(); idle();
        chk_ch(0, 8'h0F, "t6_bad_ch0");
        chk_ch(1, 8'h00, "t6_bad_ch1");
        chk_ch(2, 8'h00, "t6_bad_ch2");
        step(1, 1, 8'hFF, 0, 0);
        ticks(3);
        step(1, 1, 8'h80, 1, 0); idle();
        chk_ch(1, 8'h4F, "t6_upd_tick");

        for (int i = 0; i < 600; i++) begin
            int sel;
            int d;
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            sel = $urandom_range(0, 3);
            d = sel == 0 ? 0 : sel == 1 ? 255 : $urandom_range(0, 255);
            step($urandom_range(0, 1) == 1, $urandom_range(0, 3), d,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0);
        end
        idle();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected values still queued, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ste_led_meter.md
Name: ste_led_meter

Overview:
- Multi-channel LED level meter. Successor to the single-channel LED bar display.
- Each channel scales an input sample to a bar length and keeps a peak-hold marker. After a programmable hold time, the marker decays one LED per decay tick.
- Sits after the STE/RMS calculation, directly driving the board LED banks. A display mode selects bar or dot rendering.

Parameters:
- DATA_W, 8: width of the input sample (unsigned).
- LED_NR, 8: LEDs per channel.
- CH_NR, 3: number of independent channels.
- HOLD_TICKS, 3: tick_i pulses the peak marker is held before decay starts.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- din_i  in  DATA_W  sample value.
- din_ch_i  in  $clog2(CH_NR)  channel index for din_i.
- din_update_i  in  1  1-clock strobe: din_i/din_ch_i valid.
- tick_i  in  1  1-clock decay timebase strobe, common to all channels.
- mode_i  in  1  0 = bar + peak; 1 = dot + peak.
- clr_i  in  1  synchronous clear of all channels.
- led_o  out  CH_NR*LED_NR  LED outputs; channel c occupies bits [c*LED_NR +: LED_NR]; bit 0 is the lowest LED.

Behaviour:
- Per-channel state:
  - lvl: 0..LED_NR, width $clog2(LED_NR+1).
  - pk: 0..LED_NR.
  - hold: 0..HOLD_TICKS.
- Reset (async): all lvl/pk/hold = 0; led_o = 0.
- Scaling: n = ceil(din_i*LED_NR / 2^DATA_W), computed at DATA_W+$clog2(LED_NR)+1 bits with no overflow.
  - din=0 gives 0; din=1 gives 1; din=2^DATA_W-1 gives LED_NR.
- Update, when din_update_i=1 and din_ch_i<CH_NR, for channel c:
  - lvl_c <= n.
  - If n >= pk_c: pk_c <= n and hold_c <= HOLD_TICKS.
  - Otherwise pk_c follows the tick rule below.
- din_ch_i >= CH_NR: update ignored, no state change.
- Tick rule, per channel, when tick_i=1 and that channel did not load its peak this cycle:
  - hold>0: hold decrements.
  - hold=0 and pk>lvl (lvl taken after any same-cycle update): pk decrements by 1.
  - pk never goes below lvl and never wraps below 0.
- Priority: clr_i > update/peak-load > tick.
  - clr_i=1: all state cleared and led_o <= 0 on the same edge. Update and tick are ignored that cycle.
- Rendering, registered into led_o one edge after the state change (din_update_i at edge k yields led_o at edge k+2):
  - bar (mode_i=0): bits [lvl-1:0] set.
  - dot (mode_i=1): only bit lvl-1 set (none if lvl=0).
  - Both modes: bit pk-1 also set if pk>0.
- mode_i change takes effect on led_o at the next edge, with no state change.
- Channels are fully independent except for the shared tick_i and clr_i.
- The bar is never refreshed without a strobe; state holds indefinitely when no strobes occur.

Decomposition:
- Package ste_led_pkg:
  - function thermo(n): LED_NR-bit thermometer code.
  - function onehot_at(n): single bit n-1, zero for n=0.
  - Localparams LVL_W and HOLD_W derived from LED_NR and HOLD_TICKS.
  - Typedef for the mode enum (MODE_BAR, MODE_DOT).
- Sub-module ste_led_peak_ch: one channel's scaling, lvl/pk/hold registers and rendering. It is instantiated CH_NR times in a generate loop. Top level does channel decode and output concatenation.

Test Plan (DATA_W=8, LED_NR=8, CH_NR=3, HOLD_TICKS=3):
1. Reset, then update ch0 with din=0x80, mode 0 -> n=4; two edges later led_o[7:0]=0x0F and the other channels read 0x00.
2. ch1 din=0xFF, then ch1 din=0x20 -> led_o[15:8]=0xFF, then 0x81.
   - 3 ticks: no change (hold).
   - 4th tick: 0x41.
   - 5th tick: 0x21.
   - Keep ticking until 0x01; further ticks leave 0x01.
3. ch2 din=0x01 -> 0x01; then din=0x00 -> 0x01 (peak only); after 4 ticks -> 0x00.
4. ch0 lvl=4, pk=6 (din=0xC0 then 0x80), mode_i=1 -> led_o[7:0]=0x28; mode_i=0 -> 0x2F next edge.
5. clr_i together with din_update_i and tick_i -> led_o=0 on that edge and all state zero. A subsequent tick produces no change.
6. din_ch_i=3 with din=0xFF -> no change on any channel. Also check update plus tick on the same channel with n<pk and hold=0: lvl updates and pk decrements once.
